// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Issue/sequencing stage around a DATA_W-bit ALU. An opcode and two operands
// are accepted over a valid/ready handshake and registered. The selected
// operation then runs: a single cycle for logic/shift/add/sub/mul, or
// DATA_W iterations of a restoring divide. The registered result, high word
// and status flags are returned over a second valid/ready handshake. Only one
// operation is in flight at a time.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   op/a/b valid
//   in_ready   out  stage can accept (high only in IDLE)
//   in_op      in   opcode: 0 OR, 1 AND, 2 NOT a, 3 XOR, 4 SLL1, 5 SRL1,
//                   6 ADD, 7 SUB, 8 MUL, 9 DIV, 10..15 unsupported
//   in_a       in   operand A (dividend, minuend, shift source)
//   in_b       in   operand B (divisor, subtrahend)
//   out_valid  out  result valid, held until accepted
//   out_ready  in   consumer accepts result
//   out_result out  result / quotient / low product
//   out_hi     out  high product (MUL), remainder (DIV), else 0
//   out_zero   out  out_result == 0
//   out_carry  out  ADD carry-out, SUB no-borrow (a >= b), else 0
//   err_div0   out  DIV with b == 0
//   err_op     out  unsupported opcode
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_hi,
    output logic              out_zero,
    output logic              out_carry,
    output logic              err_div0,
    output logic              err_op
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [OP_W-1:0] OP_OR  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(1);
    localparam logic [OP_W-1:0] OP_NOT = OP_W'(2);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SLL = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SRL = OP_W'(5);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(7);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(8);
    localparam logic [OP_W-1:0] OP_DIV = OP_W'(9);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DIV_ITER,
        ST_DONE
    } state_e;

    state_e              state_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   quo_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                out_valid_q;
    logic [DATA_W-1:0]   result_q;
    logic [DATA_W-1:0]   hi_q;
    logic                zero_q;
    logic                carry_q;
    logic                err_div0_q;
    logic                err_op_q;

    // Single-cycle ALU results, consumed in EXEC.
    logic [DATA_W-1:0]   alu_res_d;
    logic [DATA_W-1:0]   alu_hi_d;
    logic                alu_carry_d;
    logic                alu_err_op_d;
    logic [DATA_W:0]     sum_d;
    logic [2*DATA_W-1:0] prod_d;

    // One restoring-divide step, consumed in DIV_ITER.
    logic [DATA_W:0]     rem_shift_d;
    logic [DATA_W:0]     rem_sub_d;
    logic [DATA_W-1:0]   rem_d;
    logic [DATA_W-1:0]   quo_d;

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign out_hi     = hi_q;
    assign out_zero   = zero_q;
    assign out_carry  = carry_q;
    assign err_div0   = err_div0_q;
    assign err_op     = err_op_q;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case statement can infer a latch.
        alu_res_d    = '0;
        alu_hi_d     = '0;
        alu_carry_d  = 1'b0;
        alu_err_op_d = 1'b0;
        sum_d        = '0;
        prod_d       = '0;
        case (op_q)
            OP_OR:  alu_res_d = a_q | b_q;
            OP_AND: alu_res_d = a_q & b_q;
            OP_NOT: alu_res_d = ~a_q;
            OP_XOR: alu_res_d = a_q ^ b_q;
            OP_SLL: alu_res_d = {a_q[DATA_W-2:0], 1'b0};
            OP_SRL: alu_res_d = {1'b0, a_q[DATA_W-1:1]};
            OP_ADD: begin
                sum_d       = {1'b0, a_q} + {1'b0, b_q};
                alu_res_d   = sum_d[DATA_W-1:0];
                alu_carry_d = sum_d[DATA_W];
            end
            OP_SUB: begin
                // Extra MSB is the borrow; carry reports its inverse (a >= b).
                sum_d       = {1'b0, a_q} - {1'b0, b_q};
                alu_res_d   = sum_d[DATA_W-1:0];
                alu_carry_d = ~sum_d[DATA_W];
            end
            OP_MUL: begin
                prod_d    = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
                alu_res_d = prod_d[DATA_W-1:0];
                alu_hi_d  = prod_d[2*DATA_W-1:DATA_W];
            end
            OP_DIV: begin
                // Only reaches the outputs when b == 0; a real divide
                // goes through DIV_ITER instead.
                alu_res_d = '1;
                alu_hi_d  = a_q;
            end
            default: alu_err_op_d = 1'b1;
        endcase
    end

    always_comb begin
        // The remainder stays below b, so the shifted value fits in DATA_W+1
        // bits and the subtraction's MSB is set exactly when rem < b.
        rem_shift_d = {rem_q, quo_q[DATA_W-1]};
        rem_sub_d   = rem_shift_d - {1'b0, b_q};
        if (!rem_sub_d[DATA_W]) begin
            rem_d = rem_sub_d[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_d = rem_shift_d[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand and divider registers are reset along with the
            // outputs so that an abort mid-divide leaves no stale state behind.
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            err_div0_q  <= 1'b0;
            err_op_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the values present before this edge.
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q       <= in_op;
                        a_q        <= in_a;
                        b_q        <= in_b;
                        result_q   <= '0;
                        hi_q       <= '0;
                        zero_q     <= 1'b0;
                        carry_q    <= 1'b0;
                        err_div0_q <= 1'b0;
                        err_op_q   <= 1'b0;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_q == OP_DIV && b_q != '0) begin
                        rem_q   <= '0;
                        quo_q   <= a_q;
                        cnt_q   <= CNT_W'(DATA_W);
                        state_q <= ST_DIV_ITER;
                    end else begin
                        result_q    <= alu_res_d;
                        hi_q        <= alu_hi_d;
                        zero_q      <= (alu_res_d == '0);
                        carry_q     <= alu_carry_d;
                        err_div0_q  <= (op_q == OP_DIV);
                        err_op_q    <= alu_err_op_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DIV_ITER: begin
                    if (cnt_q != '0) begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        result_q    <= quo_q;
                        hi_q        <= rem_q;
                        zero_q      <= (quo_q == '0);
                        carry_q     <= 1'b0;
                        err_div0_q  <= 1'b0;
                        err_op_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
